fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_pc_reg.sv | 22 ++
 rtl/fetch_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The HALTED state exists only when FETCH_HALT_DETECT_EN is defined.
package fetch_stage_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]        HALT_OPCODE = 5'b00000;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_SQUASH
`ifdef FETCH_HALT_DETECT_EN
    , ST_HALTED
`endif
  } fetch_state_e;

  function automatic logic is_halt(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 5] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: asynchronous reset to RESET_PC, loads d when load=1.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake, stall hold buffer, redirect squash.
// Optional halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
  parameter logic [WORD_W-1:0] PC_STEP  = 16'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_rd,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_done,
  output logic [WORD_W-1:0] pc_inc,
  output logic [WORD_W-1:0] instr,
  output logic              if_nop,
  output logic              halted
);

  fetch_state_e      state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_seq;
  logic [WORD_W-1:0] hold_instr;
  logic [WORD_W-1:0] hold_pc_inc;
  logic              in_halted;
  logic              deliver;
  logic              from_hold;
  logic              halt_now;
  logic              redirect_act;
  logic              pc_load;
  logic [WORD_W-1:0] pc_d;

  assign pc_seq = pc + PC_STEP;

`ifdef FETCH_HALT_DETECT_EN
  assign in_halted = (state == ST_HALTED);
`else
  assign in_halted = 1'b0;
`endif

  // Redirect is inert in HALTED and during reset.
  assign redirect_act = redirect && !in_halted && !rst;

  always_comb begin
    deliver   = 1'b0;
    from_hold = 1'b0;
    case (state)
      ST_REQ, ST_WAIT: deliver   = imem_done && !redirect_act;
      ST_HOLD:         from_hold = !redirect_act;
      default:         ;
    endcase
    if (rst) begin
      deliver   = 1'b0;
      from_hold = 1'b0;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  assign halt_now = (deliver && is_halt(imem_rdata)) || (from_hold && is_halt(hold_instr));
`else
  assign halt_now = 1'b0;
`endif

  // A delivered HALT freezes the PC at the HALT address.
  always_comb begin
    pc_load = 1'b0;
    pc_d    = pc_seq;
    if (redirect_act) begin
      pc_load = 1'b1;
      pc_d    = redirect_pc;
    end else if ((deliver || from_hold) && !stall_in && !halt_now) begin
      pc_load = 1'b1;
    end
  end

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc)
  );

  always_comb begin
    imem_rd   = (state == ST_REQ) && !rst;
    imem_addr = pc;
    if_nop    = !(deliver || from_hold);
    instr     = NOP_INSTR;
    pc_inc    = pc_seq;
    if (deliver) begin
      instr = imem_rdata;
    end else if (from_hold) begin
      instr  = hold_instr;
      pc_inc = hold_pc_inc;
    end
    halted = in_halted;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_REQ;
      hold_instr  <= '0;
      hold_pc_inc <= '0;
    end else if (redirect_act) begin
      hold_instr  <= '0;
      hold_pc_inc <= '0;
      // An outstanding access must be drained before issuing the new one.
      if ((state == ST_WAIT || state == ST_SQUASH) && !imem_done) begin
        state <= ST_SQUASH;
      end else begin
        state <= ST_REQ;
      end
    end else begin
      case (state)
        ST_REQ, ST_WAIT: begin
          if (deliver) begin
            if (stall_in) begin
              state       <= ST_HOLD;
              hold_instr  <= imem_rdata;
              hold_pc_inc <= pc_seq;
            end else if (halt_now) begin
`ifdef FETCH_HALT_DETECT_EN
              state <= ST_HALTED;
`endif
            end else begin
              state <= ST_REQ;
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!stall_in) begin
            if (halt_now) begin
`ifdef FETCH_HALT_DETECT_EN
              state <= ST_HALTED;
`endif
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_SQUASH: begin
          if (imem_done) begin
            state <= ST_REQ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
